// File: rtl/rom_load_ctrl.sv
// Purpose: load a program image into the instruction ROM. Bytes are packed into little-endian words and written from address 0.
// Latency: one WRITE cycle after each 4th byte, then DONE one cycle after the last write. The optional checksum adds the CHK step first.
// Backpressure: byte_rdy_o is low outside RECV/CHK. Optional checksum: define ROM_LOAD_CHKSUM_EN.
module rom_load_ctrl #(
    parameter int DEPTH       = 4096,
    parameter int CNT_W       = 13,
    parameter int TIMEOUT_CYC = 50000   // must be >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_words_i,
    input  logic             byte_vld_i,
    input  logic [7:0]       byte_i,
    output logic             byte_rdy_o,
    output logic             w_en_o,
    output logic [31:0]      w_addr_o,
    output logic [31:0]      w_data_o,
    input  logic             core_r_en_i,
    output logic             r_en_o,
    output logic             hold_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] words_o
);

    localparam int TO_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       lane_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] words_q;
    logic [31:0]      data_q;
    logic             err_q;
    logic [CNT_W-1:0] len_in_eff;
    logic             accepting;
    logic             start_acc;
    logic             byte_acc;
    logic             to_hit;
    logic             last_word;

    // The clamp keeps the highest address at (DEPTH-1)*4, so the address never wraps.
    assign len_in_eff = (len_words_i > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : len_words_i;
    assign accepting  = (state_q == S_RECV) || (state_q == S_CHK);
    assign start_acc  = start_i && (state_q == S_IDLE);
    assign byte_acc   = byte_vld_i && accepting;
    // The idle cycle that brings the count to TIMEOUT_CYC-1 is the one that aborts.
    assign to_hit     = !byte_acc && (to_cnt_q == TO_W'(TIMEOUT_CYC - 2));
    assign last_word  = (CNT_W'(words_q + 1'b1) == len_q);

    assign w_addr_o = 32'({words_q, 2'b00});
    assign w_data_o = data_q;
    assign words_o  = words_q;
    assign err_o    = err_q;
    assign hold_o   = busy_o;
    assign r_en_o   = core_r_en_i & ~hold_o;

`ifdef ROM_LOAD_CHKSUM_EN
    logic [7:0] sum_q;

    // The running sum covers data bytes only. The checksum byte taken in CHK is not added.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (start_acc) begin
            sum_q <= '0;
        end else if (byte_acc && (state_q == S_RECV)) begin
            sum_q <= sum_q + byte_i;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d    = state_q;
        byte_rdy_o = 1'b0;
        w_en_o     = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_in_eff == '0) begin
`ifdef ROM_LOAD_CHKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                byte_rdy_o = 1'b1;
                busy_o     = 1'b1;
                if (byte_acc && (lane_q == 2'd3)) begin
                    state_d = S_WRITE;
                end else if (to_hit) begin
                    state_d = S_ERR;
                end
            end
            S_WRITE: begin
                w_en_o = 1'b1;
                busy_o = 1'b1;
                if (last_word) begin
`ifdef ROM_LOAD_CHKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_RECV;
                end
            end
            S_CHK: begin
                byte_rdy_o = 1'b1;
                busy_o     = 1'b1;
`ifdef ROM_LOAD_CHKSUM_EN
                if (byte_acc) begin
                    state_d = (byte_i == sum_q) ? S_DONE : S_ERR;
                end else if (to_hit) begin
                    state_d = S_ERR;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: capture the length, pack bytes into lanes, count written words, run the timeout and set the sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q   <= '0;
            to_cnt_q <= '0;
            len_q    <= '0;
            words_q  <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= (accepting && !byte_acc) ? TO_W'(to_cnt_q + 1'b1) : '0;
            if (start_acc) begin
                len_q   <= len_in_eff;
                words_q <= '0;
                err_q   <= 1'b0;
                lane_q  <= '0;
            end
            if (byte_acc && (state_q == S_RECV)) begin
                data_q[{lane_q, 3'b000} +: 8] <= byte_i;
                lane_q                        <= lane_q + 2'd1;
            end
            if (state_q == S_WRITE) begin
                words_q <= words_q + 1'b1;
                lane_q  <= '0;
            end
            // An abort discards any partial word. Words already written keep their count.
            if (state_d == S_ERR) begin
                err_q  <= 1'b1;
                lane_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rom_load_ctrl.sv
`timescale 1ns/1ps
// Bench for rom_load_ctrl: expected ROM writes are queued as bytes are driven and compared as w_en_o fires.
// Runs with TIMEOUT_CYC=16 so the abort timing is short. Back-to-back bytes never get close to it.
// Sections that need ROM_LOAD_CHKSUM_EN are compiled only when that macro is defined.
module tb_rom_load_ctrl;

    localparam int CNT_W = 13;

    logic             clk;
    logic             rst;
    logic             start_i;
    logic [CNT_W-1:0] len_words_i;
    logic             byte_vld_i;
    logic [7:0]       byte_i;
    logic             byte_rdy_o;
    logic             w_en_o;
    logic [31:0]      w_addr_o;
    logic [31:0]      w_data_o;
    logic             core_r_en_i;
    logic             r_en_o;
    logic             hold_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [CNT_W-1:0] words_o;

    rom_load_ctrl #(.DEPTH(4096), .CNT_W(CNT_W), .TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .len_words_i (len_words_i),
        .byte_vld_i  (byte_vld_i),
        .byte_i      (byte_i),
        .byte_rdy_o  (byte_rdy_o),
        .w_en_o      (w_en_o),
        .w_addr_o    (w_addr_o),
        .w_data_o    (w_data_o),
        .core_r_en_i (core_r_en_i),
        .r_en_o      (r_en_o),
        .hold_o      (hold_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .words_o     (words_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_chk   = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    int          n_wr    = 0;
    int          ren_bad = 0;
    int          last_wr_cyc = 0;
    int          acc_cyc = 0;
    logic [31:0] last_wr_addr = '0;
    logic [7:0]  exp_sum = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Write monitor: each w_en_o pops the oldest expected write. Read gating is tallied every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (r_en_o !== (core_r_en_i & ~hold_o)) ren_bad++;
            if (w_en_o) begin
                n_wr++;
                last_wr_cyc  = cyc;
                last_wr_addr = w_addr_o;
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", w_addr_o, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", w_addr_o, e.addr);
                    chk("wr_data", w_data_o, e.data);
                end
            end
        end
    end

    // Every task below starts and ends at a negedge.
    task automatic do_start(input int len);
        start_i     = 1'b1;
        len_words_i = CNT_W'(len);
        @(negedge clk);
        start_i     = 1'b0;
        exp_sum     = '0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t          = 0;
        byte_i     = b;
        byte_vld_i = 1'b1;
        while (!byte_rdy_o && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) chk("byte_accept", 32'(byte_rdy_o), 32'd1);
        @(negedge clk);
        byte_vld_i = 1'b0;
        acc_cyc    = cyc;
        exp_sum    = exp_sum + b;
    endtask

    task automatic send_word(input int idx, input logic [31:0] data);
        exp_q.push_back('{addr: 32'(idx) << 2, data: data});
        for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
    endtask

    task automatic finish_load();
`ifdef ROM_LOAD_CHKSUM_EN
        send_byte(exp_sum);
`endif
    endtask

    task automatic wait_done(input string tag, input int exp_words);
        int t;
        t = 0;
        while (!done_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(done_o), 32'd1);
        chk({tag, "_words"}, 32'(words_o), 32'(exp_words));
        chk({tag, "_hold"}, 32'(hold_o), 32'd0);
`ifndef ROM_LOAD_CHKSUM_EN
        if (exp_words > 0) chk({tag, "_lat"}, 32'(cyc - last_wr_cyc), 32'd1);
`endif
        @(negedge clk);
    endtask

    task automatic wait_err(input string tag);
        int t;
        t = 0;
        while (!err_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(err_o), 32'd1);
    endtask

    initial begin
        int w0;
        rst         = 1'b1;
        start_i     = 1'b0;
        len_words_i = '0;
        byte_vld_i  = 1'b0;
        byte_i      = '0;
        core_r_en_i = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst_rdy",   32'(byte_rdy_o), 32'd0);
        chk("rst_wen",   32'(w_en_o),     32'd0);
        chk("rst_hold",  32'(hold_o),     32'd0);
        chk("rst_busy",  32'(busy_o),     32'd0);
        chk("rst_done",  32'(done_o),     32'd0);
        chk("rst_err",   32'(err_o),      32'd0);
        chk("rst_addr",  w_addr_o,        32'd0);
        chk("rst_data",  w_data_o,        32'd0);
        chk("rst_words", 32'(words_o),    32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ren_idle_pre", 32'(r_en_o), 32'd1);

        // Basic two-word load.
        do_start(2);
        chk("hold_after_start", 32'(hold_o), 32'd1);
        chk("ren_during_load", 32'(r_en_o), 32'd0);
        exp_q.push_back('{addr: 32'h0, data: 32'h1234_5678});
        exp_q.push_back('{addr: 32'h4, data: 32'hDEAD_BEEF});
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        finish_load();
        wait_done("basic_done", 2);
        chk("basic_last_addr", last_wr_addr, 32'h4);
        chk("ren_idle_post", 32'(r_en_o), 32'd1);

        // Timeout: two bytes, then the stream stalls.
        w0 = n_wr;
        do_start(1);
        send_byte(8'hA1); send_byte(8'hA2);
        wait_err("to_err");
        chk("to_delay", 32'(cyc - acc_cyc), 32'd15);
        chk("to_busy", 32'(busy_o), 32'd0);
        chk("to_nowr", 32'(n_wr - w0), 32'd0);
        chk("to_words", 32'(words_o), 32'd0);
        repeat (5) @(negedge clk);
        chk("to_sticky", 32'(err_o), 32'd1);
        do_start(1);
        chk("err_cleared", 32'(err_o), 32'd0);
        send_word(0, 32'h0BAD_F00D);
        finish_load();
        wait_done("after_err_done", 1);

        // Zero length: done without any write.
        w0 = n_wr;
        do_start(0);
        finish_load();
        wait_done("len0_done", 0);
        chk("len0_nowr", 32'(n_wr - w0), 32'd0);

        // A second start mid-load is ignored. The load still runs its 3 words.
        do_start(3);
        send_word(0, 32'h1111_2222);
        start_i = 1'b1; len_words_i = CNT_W'(1);
        @(negedge clk);
        start_i = 1'b0;
        send_word(1, 32'h3333_4444);
        chk("busy_ignored_start", 32'(busy_o), 32'd1);
        send_word(2, 32'h5555_6666);
        finish_load();
        wait_done("busy_done", 3);

        // Reset mid-word, then a fresh load starting at address 0.
        do_start(2);
        send_word(0, 32'hCAFE_0001);
        send_byte(8'h01); send_byte(8'h02);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_busy",  32'(busy_o),     32'd0);
        chk("mr_rdy",   32'(byte_rdy_o), 32'd0);
        chk("mr_hold",  32'(hold_o),     32'd0);
        chk("mr_words", 32'(words_o),    32'd0);
        chk("mr_addr",  w_addr_o,        32'd0);
        chk("mr_data",  w_data_o,        32'd0);
        rst = 1'b0;
        @(negedge clk);
        do_start(1);
        send_word(0, 32'h7777_8888);
        finish_load();
        wait_done("mr_reload_done", 1);

        // Over-long length clamps to the ROM depth.
        do_start(5000);
        for (int i = 0; i < 4096; i++) send_word(i, $urandom);
        finish_load();
        wait_done("clamp_done", 4096);
        chk("clamp_last_addr", last_wr_addr, 32'h3FFC);

`ifdef ROM_LOAD_CHKSUM_EN
        // Checksum good, then bad. The data word is written in both cases.
        do_start(1);
        exp_q.push_back('{addr: 32'h0, data: 32'h0403_0201});
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h0A);
        wait_done("cs_good", 1);
        do_start(1);
        exp_q.push_back('{addr: 32'h0, data: 32'h0403_0201});
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h0B);
        wait_err("cs_bad");
        chk("cs_bad_words", 32'(words_o), 32'd1);
`endif

        repeat (3) @(negedge clk);
        chk("ren_gate", 32'(ren_bad), 32'd0);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
